// File: rtl/rf_pkg.sv
// Shared types and constants for the architectural register file and its
// write-back scoreboard.
package rf_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = 5;
  localparam int CNT_W  = REG_AW + 1;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  function automatic cnt_t popcount(input logic [NREGS-1:0] v);
    cnt_t c;
    c = '0;
    for (int i = 0; i < NREGS; i++) begin
      c = c + cnt_t'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: set at accepted issue, cleared at write-back,
// producing the decode stall and a registered count of pending registers.
module rf_scoreboard
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      rf_we,
  input  reg_addr_t rf_rd_addr,
  input  reg_addr_t rs1_addr,
  input  reg_addr_t rs2_addr,
  input  logic      iss_valid,
  input  logic      iss_rd_we,
  input  reg_addr_t iss_rd_addr,
  output logic      iss_stall,
  output cnt_t      pend_cnt
);

  localparam logic [NREGS-1:0] BIT0 = {{(NREGS-1){1'b0}}, 1'b1};

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] set_v, clr_v;
  cnt_t             pend_cnt_q, pend_cnt_d;
  logic             stall_s;
  logic             accept_s;

  // A same-cycle write-back to the register resolves the hazard.
  function automatic logic hazard(input logic [NREGS-1:0] pend, input logic we,
                                  input reg_addr_t wa, input reg_addr_t a);
    return pend[a] && !(we && (wa == a)) && (a != '0);
  endfunction

  // Stall decision and next-state of the pending vector (set wins over clear).
  always_comb begin
    stall_s = iss_valid &&
              (hazard(pending_q, rf_we, rf_rd_addr, rs1_addr) ||
               hazard(pending_q, rf_we, rf_rd_addr, rs2_addr) ||
               (iss_rd_we && hazard(pending_q, rf_we, rf_rd_addr, iss_rd_addr)));
    accept_s   = iss_valid && !stall_s;
    clr_v      = rf_we ? (BIT0 << rf_rd_addr) : '0;
    set_v      = (accept_s && iss_rd_we && (iss_rd_addr != '0)) ? (BIT0 << iss_rd_addr) : '0;
    pending_d  = (pending_q & ~clr_v) | set_v;
    pend_cnt_d = popcount(pending_d);
  end

  // Scoreboard state and its population count update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      pend_cnt_q <= '0;
    end else begin
      pending_q  <= pending_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign iss_stall = stall_s;
  assign pend_cnt  = pend_cnt_q;

endmodule

// File: rtl/rf_wb_sink.sv
// Architectural register file receiving write-back results, with two
// write-first bypassed decode read ports and the issue scoreboard.
module rf_wb_sink
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rf_we,
  input  logic [4:0]       rf_rd_addr,
  input  logic [XLEN-1:0]  rf_rd_data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             iss_valid,
  input  logic             iss_rd_we,
  input  logic [4:0]       iss_rd_addr,
  output logic             iss_stall,
  output logic [5:0]       pend_cnt
);

  xlen_t regs_q [NREGS];
  xlen_t regs_d [NREGS];

  // Register-file next state; x0 is held at zero.
  always_comb begin
    regs_d[0] = '0;
    for (int i = 1; i < NREGS; i++) begin
      regs_d[i] = (rf_we && (rf_rd_addr == reg_addr_t'(i))) ? rf_rd_data : regs_q[i];
    end
  end

  // Register array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-first bypass from the write-back bus.
  always_comb begin
    rs1_data = (rs1_addr == '0) ? '0 :
               (rf_we && (rf_rd_addr == rs1_addr)) ? rf_rd_data : regs_q[rs1_addr];
    rs2_data = (rs2_addr == '0) ? '0 :
               (rf_we && (rf_rd_addr == rs2_addr)) ? rf_rd_data : regs_q[rs2_addr];
  end

  rf_scoreboard u_sb (
    .clk         (clk),
    .rst_n       (rst_n),
    .rf_we       (rf_we),
    .rf_rd_addr  (rf_rd_addr),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .iss_valid   (iss_valid),
    .iss_rd_we   (iss_rd_we),
    .iss_rd_addr (iss_rd_addr),
    .iss_stall   (iss_stall),
    .pend_cnt    (pend_cnt)
  );

endmodule

// File: tb/tb_rf_wb_sink.sv
// Randomized self-checking bench for rf_wb_sink against a behavioural model
// of the register file and the pending-write set.
module tb_rf_wb_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_rd_addr;
  logic [31:0] rf_rd_data;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic        iss_valid, iss_rd_we;
  logic [4:0]  iss_rd_addr;
  logic        iss_stall;
  logic [5:0]  pend_cnt;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  rf_wb_sink dut (
    .clk(clk), .rst_n(rst_n), .rf_we(rf_we), .rf_rd_addr(rf_rd_addr),
    .rf_rd_data(rf_rd_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .iss_valid(iss_valid),
    .iss_rd_we(iss_rd_we), .iss_rd_addr(iss_rd_addr), .iss_stall(iss_stall),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  function automatic int m_cnt();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_pend[i]);
    return c;
  endfunction

  function automatic bit m_hazard(int a);
    return (a != 0) && m_pend[a] && !(rf_we && (int'(rf_rd_addr) == a));
  endfunction

  function automatic bit m_stall();
    if (!iss_valid) return 1'b0;
    return m_hazard(int'(rs1_addr)) || m_hazard(int'(rs2_addr)) ||
           (iss_rd_we && m_hazard(int'(iss_rd_addr)));
  endfunction

  function automatic logic [31:0] m_read(int a);
    if (a == 0) return 32'd0;
    if (rf_we && (int'(rf_rd_addr) == a)) return rf_rd_data;
    return m_regs[a];
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'd0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic idle();
    rf_we = 1'b0; rf_rd_addr = 5'd0; rf_rd_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    iss_valid = 1'b0; iss_rd_we = 1'b0; iss_rd_addr = 5'd0;
  endtask

  // Advance one clock edge and apply the same edge to the model.
  task automatic tick();
    bit acc;
    acc = iss_valid && !m_stall();
    @(posedge clk);
    if (rf_we) begin
      if (rf_rd_addr != 5'd0) m_regs[rf_rd_addr] = rf_rd_data;
      m_pend[rf_rd_addr] = 1'b0;
    end
    if (acc && iss_rd_we && (iss_rd_addr != 5'd0)) m_pend[iss_rd_addr] = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    m_clear();
    iss_valid = 1'b1; iss_rd_we = 1'b1; rs1_addr = 5'd3;
    #1;
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", pend_cnt); end
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", iss_stall); end
    #6 rst_n = 1'b1;
    idle();
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a); rs2_addr = 5'(31 - a);
      #1;
      total++;
      if (rs1_data !== 32'd0 || rs2_data !== 32'd0) begin
        bad++; $display("FAIL reset_read a=%0d got=%h/%h exp=0", a, rs1_data, rs2_data);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    idle();
    rf_we = 1'b1; rf_rd_addr = 5'd10; rf_rd_data = 32'h1234_5678;
    tick();
    idle(); rs2_addr = 5'd10;
    #1;
    total++; if (rs2_data !== 32'h1234_5678) begin bad++; $display("FAIL write_read got=%h exp=12345678", rs2_data); end
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL write_cnt got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_bypass();
    idle();
    rf_we = 1'b1; rf_rd_addr = 5'd12; rf_rd_data = 32'hCAFE_BABE; rs1_addr = 5'd12;
    #1;
    total++; if (rs1_data !== 32'hCAFE_BABE) begin bad++; $display("FAIL bypass got=%h exp=cafebabe", rs1_data); end
    tick();
    idle(); rs1_addr = 5'd12;
    #1;
    total++; if (rs1_data !== 32'hCAFE_BABE) begin bad++; $display("FAIL bypass_stored got=%h exp=cafebabe", rs1_data); end
  endtask

  task automatic test_x0();
    idle();
    rf_we = 1'b1; rf_rd_addr = 5'd0; rf_rd_data = 32'hFFFF_FFFF;
    #1;
    total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL x0_bypass got=%h exp=0", rs1_data); end
    tick();
    idle();
    #1;
    total++; if (rs2_data !== 32'd0) begin bad++; $display("FAIL x0_read got=%h exp=0", rs2_data); end
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd_addr = 5'd0;
    tick();
    idle();
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL x0_pend got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_stall();
    idle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd_addr = 5'd5;
    #1;
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL stall_first got=%b exp=0", iss_stall); end
    tick();
    idle();
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL stall_cnt1 got=%0d exp=1", pend_cnt); end
    iss_valid = 1'b1; rs1_addr = 5'd5; iss_rd_addr = 5'd9;
    #1;
    total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL stall_raw got=%b exp=1", iss_stall); end
    idle();
    iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd_addr = 5'd5;
    #1;
    total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL stall_waw got=%b exp=1", iss_stall); end
    rf_we = 1'b1; rf_rd_addr = 5'd5; rf_rd_data = 32'h0000_0055;
    #1;
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL stall_release got=%b exp=0", iss_stall); end
    tick();
    idle();
    total++; if (pend_cnt !== 6'd1) begin bad++; $display("FAIL stall_setwins got=%0d exp=1", pend_cnt); end
    iss_valid = 1'b1; rs2_addr = 5'd5;
    #1;
    total++; if (iss_stall !== 1'b1) begin bad++; $display("FAIL stall_still got=%b exp=1", iss_stall); end
    idle();
    rf_we = 1'b1; rf_rd_addr = 5'd5; rf_rd_data = 32'h0000_0066;
    tick();
    idle();
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL stall_cleared got=%0d exp=0", pend_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    bit es;
    for (int n = 0; n < 400; n++) begin
      rf_we       = ($urandom_range(0, 2) == 0);
      rf_rd_addr  = 5'($urandom_range(0, 9));
      rf_rd_data  = $urandom;
      rs1_addr    = 5'($urandom_range(0, 11));
      rs2_addr    = 5'($urandom_range(0, 31));
      iss_valid   = ($urandom_range(0, 3) != 0);
      iss_rd_we   = ($urandom_range(0, 3) != 0);
      iss_rd_addr = 5'($urandom_range(0, 9));
      #1;
      e1 = m_read(int'(rs1_addr));
      e2 = m_read(int'(rs2_addr));
      es = m_stall();
      total++; if (rs1_data !== e1) begin bad++; $display("FAIL rnd_rs1 n=%0d a=%0d got=%h exp=%h", n, rs1_addr, rs1_data, e1); end
      total++; if (rs2_data !== e2) begin bad++; $display("FAIL rnd_rs2 n=%0d a=%0d got=%h exp=%h", n, rs2_addr, rs2_data, e2); end
      total++; if (iss_stall !== es) begin bad++; $display("FAIL rnd_stall n=%0d got=%b exp=%b", n, iss_stall, es); end
      tick();
      total++; if (int'(pend_cnt) != m_cnt()) begin bad++; $display("FAIL rnd_cnt n=%0d got=%0d exp=%0d", n, pend_cnt, m_cnt()); end
    end
    idle();
  endtask

  task automatic test_async_reset();
    idle();
    for (int a = 1; a < 32; a++) begin
      if (m_pend[a]) begin
        rf_we = 1'b1; rf_rd_addr = 5'(a); rf_rd_data = 32'h0000_0A00 + 32'(a);
        tick();
      end
    end
    idle();
    rf_we = 1'b1; rf_rd_addr = 5'd10; rf_rd_data = 32'hA5A5_0010;
    tick();
    idle(); iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd_addr = 5'd3;
    tick();
    idle(); iss_valid = 1'b1; iss_rd_we = 1'b1; iss_rd_addr = 5'd7;
    tick();
    idle();
    total++; if (pend_cnt !== 6'd2) begin bad++; $display("FAIL areset_pre got=%0d exp=2", pend_cnt); end
    rs1_addr = 5'd10;
    #1;
    total++; if (rs1_data !== 32'hA5A5_0010) begin bad++; $display("FAIL areset_prereg got=%h exp=a5a50010", rs1_data); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    m_clear();
    #1;
    total++; if (pend_cnt !== 6'd0) begin bad++; $display("FAIL areset_cnt got=%0d exp=0", pend_cnt); end
    total++; if (rs1_data !== 32'd0) begin bad++; $display("FAIL areset_reg got=%h exp=0", rs1_data); end
    iss_valid = 1'b1; rs2_addr = 5'd3;
    #1;
    total++; if (iss_stall !== 1'b0) begin bad++; $display("FAIL areset_stall got=%b exp=0", iss_stall); end
    idle();
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(negedge clk);
    rf_we = 1'b1; rf_rd_addr = 5'd4; rf_rd_data = 32'h0BAD_F00D;
    tick();
    idle(); rs2_addr = 5'd4;
    #1;
    total++; if (rs2_data !== 32'h0BAD_F00D) begin bad++; $display("FAIL areset_post got=%h exp=0badf00d", rs2_data); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_stall();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
